// File: rtl/jk_excitation_driver.sv
// Turns a requested next-state vector into one-cycle J/K pulses for an external
// JK flip-flop bank, verifies the fed-back Q, retries on mismatch, and counts successes.
module jk_excitation_driver #(
    parameter int WIDTH         = 4,
    parameter int PREFER_TOGGLE = 0,
    parameter int MAX_RETRY     = 2,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] target,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] txn_count
);

    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] MAX_RETRY_R = RW'(MAX_RETRY);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic [WIDTH-1:0] j_q, j_d;
    logic [WIDTH-1:0] k_q, k_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] exc_src;
    logic [WIDTH-1:0] rise, fall;
    logic [WIDTH-1:0] exc_j, exc_k;

    // In IDLE the excitation targets the incoming request; during retries the captured one.
    always_comb begin
        exc_src = (state_q == IDLE) ? target : tgt_q;
        rise    = ~q_fb & exc_src;
        fall    = q_fb & ~exc_src;
        exc_j   = (PREFER_TOGGLE != 0) ? (rise | fall) : rise;
        exc_k   = (PREFER_TOGGLE != 0) ? (rise | fall) : fall;
    end

    // NOTE: every variable assigned below gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        retry_d = retry_q;
        j_d     = '0;
        k_d     = '0;
        done_d  = 1'b0;
        error_d = error_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (tgt_valid) begin
                    tgt_d   = target;
                    error_d = 1'b0;
                    retry_d = '0;
                    j_d     = exc_j;
                    k_d     = exc_k;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                state_d = CHECK;
            end
            CHECK: begin
                if (q_fb == tgt_q) begin
                    done_d  = 1'b1;
                    if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                    state_d = IDLE;
                end else if (retry_q < MAX_RETRY_R) begin
                    retry_d = retry_q + RW'(1);
                    j_d     = exc_j;
                    k_d     = exc_k;
                    state_d = DRIVE;
                end else begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            tgt_q   <= '0;
            retry_q <= '0;
            j_q     <= '0;
            k_q     <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            retry_q <= retry_d;
            j_q     <= j_d;
            k_q     <= k_d;
            done_q  <= done_d;
            error_q <= error_d;
            cnt_q   <= cnt_d;
        end
    end

    assign tgt_ready = (state_q == IDLE);
    assign j         = j_q;
    assign k         = k_q;
    assign done      = done_q;
    assign error     = error_q;
    assign txn_count = cnt_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Directed bench: three driver instances (set/reset, toggle, 2-bit counter) each
// feeding a behavioural JK bank that can be preloaded or held stuck.
module tb_jk_excitation_driver;

    logic clk;
    logic reset;

    logic [2:0][3:0] target;
    logic [2:0]      tgt_valid;
    logic [2:0]      tgt_ready;
    logic [2:0][3:0] q_fb;
    logic [2:0][3:0] j;
    logic [2:0][3:0] k;
    logic [2:0]      done;
    logic [2:0]      error;
    logic [7:0]      cnt0, cnt1;
    logic [1:0]      cnt2;
    logic [2:0][7:0] cnt;

    logic [2:0][3:0] bank_q;
    logic [2:0]      bank_ld;
    logic [2:0][3:0] bank_ld_val;
    logic [2:0]      stuck;

    int n_checks = 0;
    int n_fail   = 0;

    assign cnt[0] = cnt0;
    assign cnt[1] = cnt1;
    assign cnt[2] = {6'b0, cnt2};
    assign q_fb   = bank_q;

    jk_excitation_driver #(.WIDTH(4), .PREFER_TOGGLE(0), .MAX_RETRY(2), .CNT_W(8)) dut0 (
        .clk(clk), .reset(reset), .target(target[0]), .tgt_valid(tgt_valid[0]),
        .tgt_ready(tgt_ready[0]), .q_fb(q_fb[0]), .j(j[0]), .k(k[0]),
        .done(done[0]), .error(error[0]), .txn_count(cnt0));

    jk_excitation_driver #(.WIDTH(4), .PREFER_TOGGLE(1), .MAX_RETRY(2), .CNT_W(8)) dut1 (
        .clk(clk), .reset(reset), .target(target[1]), .tgt_valid(tgt_valid[1]),
        .tgt_ready(tgt_ready[1]), .q_fb(q_fb[1]), .j(j[1]), .k(k[1]),
        .done(done[1]), .error(error[1]), .txn_count(cnt1));

    jk_excitation_driver #(.WIDTH(4), .PREFER_TOGGLE(0), .MAX_RETRY(2), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .target(target[2]), .tgt_valid(tgt_valid[2]),
        .tgt_ready(tgt_ready[2]), .q_fb(q_fb[2]), .j(j[2]), .k(k[2]),
        .done(done[2]), .error(error[2]), .txn_count(cnt2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External JK bank: Q+ = J&~Q | ~K&Q, with preload and stuck overrides.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (bank_ld[i])     bank_q[i] <= bank_ld_val[i];
            else if (!stuck[i]) bank_q[i] <= (j[i] & ~bank_q[i]) | (~k[i] & bank_q[i]);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_bank(input int idx, input logic [3:0] v);
        bank_ld[idx]     = 1'b1;
        bank_ld_val[idx] = v;
        @(negedge clk);
        bank_ld[idx]     = 1'b0;
    endtask

    // Called at a negedge with the driver idle; walks DRIVE, CHECK and the done cycle.
    task automatic run_txn(input int idx, input logic [3:0] tgt, input logic [3:0] ej,
                           input logic [3:0] ek, input logic [7:0] ecnt);
        check($sformatf("ready_before[%0d]", idx), 32'(tgt_ready[idx]), 32'd1);
        target[idx]    = tgt;
        tgt_valid[idx] = 1'b1;
        @(negedge clk);
        tgt_valid[idx] = 1'b0;
        check($sformatf("drive_j[%0d]", idx), 32'(j[idx]), 32'(ej));
        check($sformatf("drive_k[%0d]", idx), 32'(k[idx]), 32'(ek));
        check($sformatf("drive_ready[%0d]", idx), 32'(tgt_ready[idx]), 32'd0);
        check($sformatf("drive_error[%0d]", idx), 32'(error[idx]), 32'd0);
        @(negedge clk);
        check($sformatf("check_jk[%0d]", idx), 32'({j[idx], k[idx]}), 32'd0);
        check($sformatf("check_done[%0d]", idx), 32'(done[idx]), 32'd0);
        @(negedge clk);
        check($sformatf("done[%0d]", idx), 32'(done[idx]), 32'd1);
        check($sformatf("done_ready[%0d]", idx), 32'(tgt_ready[idx]), 32'd1);
        check($sformatf("done_error[%0d]", idx), 32'(error[idx]), 32'd0);
        check($sformatf("bank_q[%0d]", idx), 32'(q_fb[idx]), 32'(tgt));
        check($sformatf("txn_count[%0d]", idx), 32'(cnt[idx]), 32'(ecnt));
        @(negedge clk);
        check($sformatf("done_drop[%0d]", idx), 32'(done[idx]), 32'd0);
    endtask

    typedef struct {
        logic [3:0] q_init;
        logic [3:0] tgt;
        logic [3:0] exp_j;
        logic [3:0] exp_k;
    } vec_t;

    vec_t vecs[5];
    vec_t sat[5];

    initial begin
        // Set/reset encoding vectors for dut0.
        vecs[0] = '{4'b0000, 4'b0101, 4'b0101, 4'b0000};
        vecs[1] = '{4'b0101, 4'b1010, 4'b1010, 4'b0101};
        vecs[2] = '{4'b1111, 4'b1111, 4'b0000, 4'b0000};
        vecs[3] = '{4'b1100, 4'b0110, 4'b0010, 4'b1000};
        vecs[4] = '{4'b0011, 4'b0000, 4'b0000, 4'b0011};
        // Back-to-back chain for dut2, starting from bank = 0011.
        sat[0]  = '{4'b0011, 4'b0011, 4'b0000, 4'b0000};
        sat[1]  = '{4'b0011, 4'b0000, 4'b0000, 4'b0011};
        sat[2]  = '{4'b0000, 4'b1000, 4'b1000, 4'b0000};
        sat[3]  = '{4'b1000, 4'b1001, 4'b0001, 4'b0000};
        sat[4]  = '{4'b1001, 4'b0001, 4'b0000, 4'b1000};

        // Reset with valid asserted and bank at 1010: nothing may be accepted.
        reset       = 1'b1;
        tgt_valid   = 3'b111;
        target      = {3{4'b0101}};
        stuck       = '0;
        bank_ld     = 3'b111;
        bank_ld_val = {3{4'b1010}};
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_jk[%0d]", i), 32'({j[i], k[i]}), 32'd0);
            check($sformatf("rst_ready[%0d]", i), 32'(tgt_ready[i]), 32'd1);
            check($sformatf("rst_done_err[%0d]", i), 32'({done[i], error[i]}), 32'd0);
            check($sformatf("rst_cnt[%0d]", i), 32'(cnt[i]), 32'd0);
        end
        reset     = 1'b0;
        tgt_valid = '0;
        bank_ld   = '0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("post_rst_jk[%0d]", i), 32'({j[i], k[i]}), 32'd0);
            check($sformatf("post_rst_q[%0d]", i), 32'(q_fb[i]), 32'b1010);
        end

        for (int v = 0; v < 5; v++) begin
            set_bank(0, vecs[v].q_init);
            run_txn(0, vecs[v].tgt, vecs[v].exp_j, vecs[v].exp_k, 8'(v + 1));
        end

        // Toggle encoding.
        set_bank(1, 4'b0110);
        run_txn(1, 4'b1100, 4'b1010, 4'b1010, 8'd1);
        set_bank(1, 4'b0000);
        run_txn(1, 4'b1111, 4'b1111, 4'b1111, 8'd2);

        // Stuck bank: three drive attempts, then sticky error without done.
        stuck[0] = 1'b1;
        set_bank(0, 4'b0000);
        target[0]    = 4'b0001;
        tgt_valid[0] = 1'b1;
        @(negedge clk);
        tgt_valid[0] = 1'b0;
        for (int r = 0; r < 3; r++) begin
            check($sformatf("stuck_j_try%0d", r), 32'(j[0]), 32'b0001);
            check($sformatf("stuck_k_try%0d", r), 32'(k[0]), 32'b0000);
            @(negedge clk);
            check($sformatf("stuck_done_try%0d", r), 32'({done[0], error[0]}), 32'd0);
            @(negedge clk);
        end
        check("stuck_error", 32'(error[0]), 32'd1);
        check("stuck_no_done", 32'(done[0]), 32'd0);
        check("stuck_ready", 32'(tgt_ready[0]), 32'd1);
        check("stuck_cnt", 32'(cnt[0]), 32'd5);
        @(negedge clk);
        check("stuck_error_sticky", 32'(error[0]), 32'd1);
        stuck[0] = 1'b0;
        run_txn(0, 4'b0001, 4'b0001, 4'b0000, 8'd6);

        // Mid-transaction reset on dut2.
        set_bank(2, 4'b0000);
        target[2]    = 4'b0011;
        tgt_valid[2] = 1'b1;
        @(negedge clk);
        tgt_valid[2] = 1'b0;
        check("mid_drive_j", 32'(j[2]), 32'b0011);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_jk", 32'({j[2], k[2]}), 32'd0);
        check("mid_rst_ready", 32'(tgt_ready[2]), 32'd1);
        @(negedge clk);
        check("mid_rst_no_done", 32'(done[2]), 32'd0);
        check("mid_rst_cnt", 32'(cnt[2]), 32'd0);

        // Saturating 2-bit counter: bank already holds 0011 from the aborted drive.
        check("sat_bank_start", 32'(q_fb[2]), 32'b0011);
        for (int s = 0; s < 5; s++) begin
            run_txn(2, sat[s].tgt, sat[s].exp_j, sat[s].exp_k, (s < 3) ? 8'(s + 1) : 8'd3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
